// File: rtl/bellek_yanitlayici_if.sv
// Initiator-side memory bus (iomem_*) shared between a request initiator and the
// SRAM responder; the initiator holds valid/addr/wdata/wstrb until ready pulses.
interface bellek_yanitlayici_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [31:0] iomem_addr;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_addr, iomem_wstrb, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/bellek_yanitlayici.sv
// Bus-to-SRAM responder: latches one request, waits BEKLEME cycles, performs a
// single SRAM access inside the TABAN window and answers with a one-cycle ready.
module bellek_yanitlayici #(
  parameter int unsigned BEKLEME = 2,
  parameter int unsigned ADR_W   = 12,
  parameter logic [31:0] TABAN   = 32'h4000_0000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  bellek_yanitlayici_if.slave bus,
  output logic               bellek_csb_o,
  output logic               bellek_web_o,
  output logic [3:0]         bellek_wmask_o,
  output logic [ADR_W-1:0]   bellek_addr_o,
  output logic [31:0]        bellek_din_o,
  input  logic [31:0]        bellek_dout_i,
  output logic               hata_o
);

  localparam logic [32:0] ALT = {1'b0, TABAN};
  localparam logic [32:0] UST = ALT + (33'd4 << ADR_W);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {BOSTA, BEKLE, ERISIM, YAKALA, YANIT} durum_t;

  durum_t           durum;
  logic [3:0]       sayac;
  logic [ADR_W-1:0] adr_q;
  logic [31:0]      veri_q;
  logic [3:0]       strb_q;
  logic             pencere_q;

  logic [32:0]      gelen_adr;
  logic             gelen_pencere;
  logic             erisim_gir;
  logic [ADR_W-1:0] k_adr;
  logic [31:0]      k_veri;
  logic [3:0]       k_strb;
  logic             k_pencere;

  // With BEKLEME=0 the access starts on the accepting edge, so the SRAM
  // controls must come from the live bus instead of the not-yet-latched copy.
  always_comb begin
    gelen_adr     = {1'b0, bus.iomem_addr} & ~33'd3;
    gelen_pencere = (gelen_adr >= ALT) && (gelen_adr < UST);
    erisim_gir    = ((durum == BOSTA) && bus.iomem_valid && (BEKLEME == 0)) ||
                    ((durum == BEKLE) && (sayac == 4'd1));
    if (durum == BOSTA) begin
      k_adr     = bus.iomem_addr[ADR_W+1:2];
      k_veri    = bus.iomem_wdata;
      k_strb    = bus.iomem_wstrb;
      k_pencere = gelen_pencere;
    end else begin
      k_adr     = adr_q;
      k_veri    = veri_q;
      k_strb    = strb_q;
      k_pencere = pencere_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      durum           <= BOSTA;
      sayac           <= 4'd0;
      adr_q           <= '0;
      veri_q          <= 32'd0;
      strb_q          <= 4'd0;
      pencere_q       <= 1'b0;
      bus.iomem_ready <= 1'b0;
      bus.iomem_rdata <= 32'd0;
      bellek_csb_o    <= 1'b1;
      bellek_web_o    <= 1'b1;
      bellek_wmask_o  <= 4'd0;
      bellek_addr_o   <= '0;
      bellek_din_o    <= 32'd0;
      hata_o          <= 1'b0;
    end else begin
      bus.iomem_ready <= 1'b0;
      bellek_csb_o    <= 1'b1;
      bellek_web_o    <= 1'b1;

      if (erisim_gir) begin
        bellek_csb_o   <= ~k_pencere;
        bellek_web_o   <= ~(k_pencere && (k_strb != 4'd0));
        bellek_wmask_o <= k_strb;
        bellek_addr_o  <= k_adr;
        bellek_din_o   <= k_veri;
      end

      case (durum)
        BOSTA: begin
          if (bus.iomem_valid) begin
            adr_q     <= bus.iomem_addr[ADR_W+1:2];
            veri_q    <= bus.iomem_wdata;
            strb_q    <= bus.iomem_wstrb;
            pencere_q <= gelen_pencere;
            if (BEKLEME == 0) begin
              durum <= ERISIM;
            end else begin
              sayac <= 4'(BEKLEME);
              durum <= BEKLE;
            end
          end
        end
        BEKLE: begin
          sayac <= sayac - 4'd1;
          if (sayac == 4'd1) durum <= ERISIM;
        end
        ERISIM: begin
          if (!pencere_q) begin
            hata_o          <= 1'b1;
            if (strb_q == 4'd0) bus.iomem_rdata <= NOP;
            bus.iomem_ready <= 1'b1;
            durum           <= YANIT;
          end else if (strb_q == 4'd0) begin
            durum <= YAKALA;
          end else begin
            bus.iomem_ready <= 1'b1;
            durum           <= YANIT;
          end
        end
        YAKALA: begin
          bus.iomem_rdata <= bellek_dout_i;
          bus.iomem_ready <= 1'b1;
          durum           <= YANIT;
        end
        YANIT:   durum <= BOSTA;
        default: durum <= BOSTA;
      endcase
    end
  end

endmodule

// File: doc/bellek_yanitlayici.md
BELLEK_YANITLAYICI -- requirements
Module: bellek_yanitlayici

Interface
REQ-001 SHALL have parameter BEKLEME, default 2, the number of wait cycles inserted before the memory access (range 0..15).
REQ-002 SHALL have parameter ADR_W, default 12, the word-address width of the backing SRAM.
REQ-003 SHALL have parameter TABAN, default 32'h4000_0000, the byte base address of the served window (size 4*2^ADR_W bytes).
REQ-004 SHALL have one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port: clk_i  input  1  clock, all state on rising edge.
REQ-006 SHALL have port: rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port: iomem_valid  input  1  request present; initiator holds it with addr/wdata/wstrb until ready.
REQ-008 SHALL have port: iomem_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have port: iomem_addr  input  32  byte address; bits [1:0] ignored.
REQ-010 SHALL have port: iomem_wstrb  input  4  byte write enables; 4'b0000 means read.
REQ-011 SHALL have port: iomem_wdata  input  32  write data.
REQ-012 SHALL have port: iomem_rdata  output  32  read data, valid while iomem_ready=1.
REQ-013 SHALL have ports to the SRAM: bellek_csb_o out 1 (active-low select), bellek_web_o out 1 (active-low write), bellek_wmask_o out 4, bellek_addr_o out ADR_W, bellek_din_o out 32, bellek_dout_i in 32 (valid the cycle after a read select).
REQ-014 SHALL have port: hata_o  output  1  sticky out-of-window access flag.

Function
REQ-015 SHALL implement FSM states BOSTA, BEKLE, ERISIM, YAKALA, YANIT.
REQ-016 In BOSTA with iomem_valid=1, SHALL latch addr, wdata, wstrb and the in-window result; go to BEKLE with counter=BEKLEME, or straight to ERISIM when BEKLEME=0.
REQ-017 In BEKLE, SHALL decrement the counter each cycle and go to ERISIM when it reaches 0 (exactly BEKLEME cycles spent in BEKLE).
REQ-018 In ERISIM for an in-window read, SHALL drive csb=0, web=1, addr=latched addr[ADR_W+1:2], then go to YAKALA.
REQ-019 In YAKALA, SHALL register bellek_dout_i into iomem_rdata and go to YANIT.
REQ-020 In ERISIM for an in-window write, SHALL drive csb=0, web=0, wmask=latched wstrb, din=latched wdata, then go directly to YANIT; iomem_rdata is unchanged.
REQ-021 In ERISIM for an out-of-window access, SHALL keep csb=1 (no SRAM access), load iomem_rdata=32'h0000_0013 (NOP) for reads, set hata_o=1, and go to YANIT.
REQ-022 In YANIT, SHALL drive iomem_ready=1 (registered, no combinational path from iomem_valid) and return to BOSTA.
REQ-023 Read latency SHALL be: valid sampled in cycle 0 -> ready in cycle BEKLEME+3; write and out-of-window access -> ready in cycle BEKLEME+2.
REQ-024 iomem_ready SHALL never be high in two consecutive cycles; a new request is accepted no earlier than the cycle after YANIT.
REQ-025 Request signals changing or valid dropping after acceptance SHALL NOT affect the transaction in flight; it completes on the latched values with its ready pulse.
REQ-026 Outside ERISIM, SHALL hold bellek_csb_o=1 and bellek_web_o=1.
REQ-027 The window check SHALL be TABAN <= addr < TABAN+4*2^ADR_W with 33-bit compare (no wrap at 32'hFFFF_FFFC).
REQ-028 hata_o SHALL stay 1 until reset.

Reset
REQ-029 While rst_ni=0, immediately and asynchronously: state=BOSTA, iomem_ready=0, iomem_rdata=0, bellek_csb_o=1, bellek_web_o=1, counter=0, hata_o=0.
REQ-030 Reset asserted mid-transaction SHALL abort it with no ready pulse; after release, the first rising edge with valid=1 starts a fresh transaction.

Verification
REQ-031 Read, BEKLEME=2: SRAM word 5 = 32'hDEAD_BEEF, valid=1 addr=32'h4000_0014 in cycle 0 -> csb=0 addr=5 in cycle 3, ready=1 rdata=32'hDEAD_BEEF in cycle 5 only.
REQ-032 Write, BEKLEME=0: addr=32'h4000_0008 wstrb=4'b0011 wdata=32'h1234_5678 -> csb=0 web=0 wmask=4'b0011 addr=2 in cycle 1, ready in cycle 2; a read of word 2 then returns 32'hxxxx_5678 with upper bytes unchanged.
REQ-033 Out of window: addr=32'h3FFF_FFFC read -> no csb low, ready in cycle BEKLEME+2 with rdata=32'h0000_0013, hata_o=1 and stays 1 across later in-window reads.
REQ-034 Back-to-back: valid held high with addr stepping +4 after each ready -> one ready per request, ready pulses separated by at least one low cycle, data matches each latched address.
REQ-035 Address change mid-wait: addr switches from 32'h4000_0000 to 32'h4000_0040 in BEKLE -> response carries word 0 data.
REQ-036 Reset pulse in YAKALA -> ready, rdata, hata_o go to 0 without waiting for a clock edge, no ready pulse; the next request completes with normal latency.
